// File: rtl/sd_img_store.sv
// sd_img_store: saves and loads fixed-size images in numbered SD card slots, keeping the next free slot in a header sector
module sd_img_store #(
    parameter int IMG_SECS  = 2000,
    parameter int MAX_SLOTS = 16,
    parameter int HDR_ADDR  = 0,
    parameter int BASE_ADDR = 1,
    parameter int SEC_WORDS = 256,
    parameter int FIFO_AW   = 10,
    localparam int SLOT_W   = $clog2(MAX_SLOTS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sd_init_done,
    input  logic              save_req,
    input  logic              load_req,
    input  logic [SLOT_W-1:0] load_slot,
    input  logic              wr_busy,
    input  logic              rd_busy,
    input  logic [15:0]       rd_data,
    input  logic              rd_data_valid,
    input  logic [FIFO_AW:0]  wfifo_cnt,
    input  logic [FIFO_AW:0]  rfifo_free,
    output logic              wr_start_en,
    output logic [31:0]       wr_sec_addr,
    output logic              wr_sel,
    output logic [15:0]       hdr_wr_data,
    output logic              rd_start_en,
    output logic [31:0]       rd_sec_addr,
    output logic              rd_sel,
    output logic              busy,
    output logic              save_done,
    output logic              load_done,
    output logic              err,
    output logic [SLOT_W-1:0] cur_slot,
    output logic [2:0]        state_o
);
    typedef enum logic [2:0] {IDLE, HDR_RD, IMG_WR, HDR_WR, IMG_RD} state_t;

    state_t            state;
    logic              pending;
    logic              pend_wr;
    logic              wr_busy_q;
    logic              rd_busy_q;
    logic              hdr_cap;
    logic [11:0]       sec_cnt;
    logic              sec_done;
    logic              can_go;
    logic              last;
    logic              slot_ok;
    logic [31:0]       img_addr;
    logic [SLOT_W-1:0] hdr_slot;
    logic [SLOT_W-1:0] nxt_slot;

    // a sector completes when the engine we started drops its busy
    assign sec_done = pending & (pend_wr ? (wr_busy_q & ~wr_busy) : (rd_busy_q & ~rd_busy));
    assign can_go   = ~pending & ~wr_busy & ~rd_busy;
    assign last     = sec_cnt == 12'(IMG_SECS - 1);
    assign slot_ok  = 32'(load_slot) < MAX_SLOTS;
    assign img_addr = 32'(BASE_ADDR) + 32'(cur_slot) * 32'(IMG_SECS) + 32'(sec_cnt);
    assign hdr_slot = (32'(rd_data) < MAX_SLOTS) ? SLOT_W'(rd_data) : '0;
    assign nxt_slot = (32'(cur_slot) == MAX_SLOTS - 1) ? '0 : cur_slot + 1'b1;
    assign busy     = state != IDLE;
    assign state_o  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= 1'b0;
            pend_wr     <= 1'b0;
            wr_busy_q   <= 1'b0;
            rd_busy_q   <= 1'b0;
            hdr_cap     <= 1'b0;
            sec_cnt     <= '0;
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            wr_sec_addr <= '0;
            rd_sec_addr <= '0;
            wr_sel      <= 1'b0;
            rd_sel      <= 1'b0;
            hdr_wr_data <= '0;
            save_done   <= 1'b0;
            load_done   <= 1'b0;
            err         <= 1'b0;
            cur_slot    <= '0;
        end else begin
            wr_busy_q   <= wr_busy;
            rd_busy_q   <= rd_busy;
            wr_start_en <= 1'b0;
            rd_start_en <= 1'b0;
            save_done   <= 1'b0;
            load_done   <= 1'b0;
            err         <= 1'b0;
            if (sec_done)
                pending <= 1'b0;
            if (!sd_init_done) begin
                state       <= IDLE;
                pending     <= 1'b0;
                sec_cnt     <= '0;
                wr_sel      <= 1'b0;
                rd_sel      <= 1'b0;
                hdr_wr_data <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (save_req) begin
                            state    <= HDR_RD;
                            rd_sel   <= 1'b0;
                            hdr_cap  <= 1'b0;
                            cur_slot <= '0;
                        end else if (load_req) begin
                            if (slot_ok) begin
                                state    <= IMG_RD;
                                cur_slot <= load_slot;
                                rd_sel   <= 1'b1;
                                sec_cnt  <= '0;
                            end else
                                err <= 1'b1;
                        end
                    end
                    HDR_RD: begin
                        if (can_go) begin
                            rd_start_en <= 1'b1;
                            rd_sec_addr <= 32'(HDR_ADDR);
                            pending     <= 1'b1;
                            pend_wr     <= 1'b0;
                        end
                        if (pending && rd_data_valid && !hdr_cap) begin
                            hdr_cap  <= 1'b1;
                            cur_slot <= hdr_slot;
                        end
                        if (sec_done) begin
                            state   <= IMG_WR;
                            sec_cnt <= '0;
                        end
                    end
                    IMG_WR: begin
                        if (can_go && 32'(wfifo_cnt) >= SEC_WORDS) begin
                            wr_start_en <= 1'b1;
                            wr_sec_addr <= img_addr;
                            pending     <= 1'b1;
                            pend_wr     <= 1'b1;
                        end
                        if (sec_done) begin
                            sec_cnt <= last ? '0 : sec_cnt + 12'd1;
                            if (last) begin
                                state       <= HDR_WR;
                                wr_sel      <= 1'b1;
                                hdr_wr_data <= 16'(nxt_slot);
                            end
                        end
                    end
                    HDR_WR: begin
                        if (can_go) begin
                            wr_start_en <= 1'b1;
                            wr_sec_addr <= 32'(HDR_ADDR);
                            pending     <= 1'b1;
                            pend_wr     <= 1'b1;
                        end
                        if (sec_done) begin
                            state       <= IDLE;
                            save_done   <= 1'b1;
                            wr_sel      <= 1'b0;
                            hdr_wr_data <= '0;
                        end
                    end
                    IMG_RD: begin
                        if (can_go && 32'(rfifo_free) >= SEC_WORDS) begin
                            rd_start_en <= 1'b1;
                            rd_sec_addr <= img_addr;
                            pending     <= 1'b1;
                            pend_wr     <= 1'b0;
                        end
                        if (sec_done) begin
                            sec_cnt <= last ? '0 : sec_cnt + 12'd1;
                            if (last) begin
                                state     <= IDLE;
                                load_done <= 1'b1;
                                rd_sel    <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sd_img_store.sv
// tb_sd_img_store: directed bench with a simple SD engine responder logging every sector start
module tb_sd_img_store;
    logic        clk = 0;
    logic        rst_n = 0;
    logic        sd_init_done = 1;
    logic        save_req = 0;
    logic        load_req = 0;
    logic [3:0]  load_slot = 0;
    logic        wr_busy = 0;
    logic        rd_busy = 0;
    logic [15:0] rd_data = 0;
    logic        rd_data_valid = 0;
    logic [10:0] wfifo_cnt = 256;
    logic [10:0] rfifo_free = 256;
    logic        wr_start_en, wr_sel, rd_start_en, rd_sel, busy, save_done, load_done, err;
    logic [31:0] wr_sec_addr, rd_sec_addr;
    logic [15:0] hdr_wr_data;
    logic [3:0]  cur_slot;
    logic [2:0]  state_o;

    logic        load_req2 = 0;
    logic [3:0]  load_slot2 = 0;
    logic        wr_start_en2, wr_sel2, rd_start_en2, rd_sel2, busy2, save_done2, load_done2, err2;
    logic [31:0] wr_sec_addr2, rd_sec_addr2;
    logic [15:0] hdr_wr_data2;
    logic [3:0]  cur_slot2;
    logic [2:0]  state_o2;

    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] hdr_word = 0;
    int wt = 0, rt = 0;
    int sd_cnt = 0, ld_cnt = 0, err_cnt = 0;
    logic [31:0] wlog[$], rlog[$];
    logic        wsel_log[$], rsel_log[$];
    logic [15:0] whdr_log[$];

    always #5 clk = ~clk;

    sd_img_store #(.IMG_SECS(4), .MAX_SLOTS(16)) dut (
        .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done), .save_req(save_req),
        .load_req(load_req), .load_slot(load_slot), .wr_busy(wr_busy), .rd_busy(rd_busy),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .wfifo_cnt(wfifo_cnt),
        .rfifo_free(rfifo_free), .wr_start_en(wr_start_en), .wr_sec_addr(wr_sec_addr),
        .wr_sel(wr_sel), .hdr_wr_data(hdr_wr_data), .rd_start_en(rd_start_en),
        .rd_sec_addr(rd_sec_addr), .rd_sel(rd_sel), .busy(busy), .save_done(save_done),
        .load_done(load_done), .err(err), .cur_slot(cur_slot), .state_o(state_o)
    );

    // second instance with a non-power-of-two slot count so out-of-range slots are expressible
    sd_img_store #(.IMG_SECS(4), .MAX_SLOTS(12)) dut2 (
        .clk(clk), .rst_n(rst_n), .sd_init_done(sd_init_done), .save_req(1'b0),
        .load_req(load_req2), .load_slot(load_slot2), .wr_busy(wr_busy), .rd_busy(rd_busy),
        .rd_data(rd_data), .rd_data_valid(rd_data_valid), .wfifo_cnt(wfifo_cnt),
        .rfifo_free(rfifo_free), .wr_start_en(wr_start_en2), .wr_sec_addr(wr_sec_addr2),
        .wr_sel(wr_sel2), .hdr_wr_data(hdr_wr_data2), .rd_start_en(rd_start_en2),
        .rd_sec_addr(rd_sec_addr2), .rd_sel(rd_sel2), .busy(busy2), .save_done(save_done2),
        .load_done(load_done2), .err(err2), .cur_slot(cur_slot2), .state_o(state_o2)
    );

    always @(negedge clk) begin
        if (wr_start_en) begin
            wlog.push_back(wr_sec_addr);
            wsel_log.push_back(wr_sel);
            whdr_log.push_back(hdr_wr_data);
            wt = 4;
        end else if (wt > 0)
            wt--;
        if (rd_start_en) begin
            rlog.push_back(rd_sec_addr);
            rsel_log.push_back(rd_sel);
            rt = 4;
        end else if (rt > 0)
            rt--;
        wr_busy = wt > 0;
        rd_busy = rt > 0;
        rd_data_valid = rt == 3;
        rd_data = hdr_word;
        if (save_done) sd_cnt++;
        if (load_done) ld_cnt++;
        if (err) err_cnt++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_logs();
        wlog.delete(); rlog.delete(); wsel_log.delete(); rsel_log.delete(); whdr_log.delete();
    endtask

    task automatic pulse_save();
        save_req = 1;
        step(1);
        save_req = 0;
    endtask

    task automatic wait_save(input int c0);
        for (int i = 0; i < 300 && sd_cnt == c0; i++) step(1);
    endtask

    task automatic test_reset();
        step(3);
        n_checks++; if (state_o !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_state: state=%0d busy=%b want 0/0", state_o, busy); end
        n_checks++; if ({wr_start_en, rd_start_en, save_done, load_done, err, wr_sel, rd_sel} !== 7'b0) begin n_fail++; $display("FAIL reset_pulses: got %b want 0", {wr_start_en, rd_start_en, save_done, load_done, err, wr_sel, rd_sel}); end
        n_checks++; if (wr_sec_addr !== 32'd0 || rd_sec_addr !== 32'd0 || hdr_wr_data !== 16'd0 || cur_slot !== 4'd0) begin n_fail++; $display("FAIL reset_regs: wa=%0d ra=%0d hdr=%0d slot=%0d want 0", wr_sec_addr, rd_sec_addr, hdr_wr_data, cur_slot); end
        sd_init_done = 0;
        rst_n = 1;
        save_req = 1;
        step(3);
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL no_init_ignore: state=%0d want 0", state_o); end
        save_req = 0;
        sd_init_done = 1;
        step(1);
        pulse_save();
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL save_enter: state=%0d want 1", state_o); end
        #1 rst_n = 0;
        #1;
        n_checks++; if (state_o !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL async_reset: state=%0d busy=%b want 0/0", state_o, busy); end
        step(1);
        rst_n = 1;
        step(10);
    endtask

    task automatic test_save_basic();
        int c0;
        clear_logs();
        hdr_word = 5; wfifo_cnt = 256; c0 = sd_cnt;
        pulse_save();
        n_checks++; if (state_o !== 3'd1 || busy !== 1'b1) begin n_fail++; $display("FAIL save_hdr_rd: state=%0d busy=%b want 1/1", state_o, busy); end
        wait_save(c0);
        n_checks++; if (sd_cnt !== c0 + 1) begin n_fail++; $display("FAIL save_timeout: done=%0d want %0d", sd_cnt - c0, 1); end
        n_checks++; if (rlog.size() !== 1 || rlog[0] !== 32'd0 || rsel_log[0] !== 1'b0) begin n_fail++; $display("FAIL save_hdr_read: n=%0d want one read at 0 sel 0", rlog.size()); end
        n_checks++; if (wlog.size() !== 5) begin n_fail++; $display("FAIL save_nwrites: got %0d want 5", wlog.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (wlog[i] !== 32'(21 + i) || wsel_log[i] !== 1'b0 || whdr_log[i] !== 16'd0) begin n_fail++; $display("FAIL save_img_wr%0d: addr=%0d sel=%b hdr=%0d want %0d/0/0", i, wlog[i], wsel_log[i], whdr_log[i], 21 + i); end
            end
            n_checks++; if (wlog[4] !== 32'd0 || wsel_log[4] !== 1'b1 || whdr_log[4] !== 16'd6) begin n_fail++; $display("FAIL save_hdr_wr: addr=%0d sel=%b data=%0d want 0/1/6", wlog[4], wsel_log[4], whdr_log[4]); end
        end
        step(3);
        n_checks++; if (sd_cnt !== c0 + 1 || state_o !== 3'd0 || busy !== 1'b0 || hdr_wr_data !== 16'd0) begin n_fail++; $display("FAIL save_after: done=%0d state=%0d hdr=%0d want 1/0/0", sd_cnt - c0, state_o, hdr_wr_data); end
    endtask

    task automatic test_save_wrap();
        int c0;
        clear_logs();
        hdr_word = 15; c0 = sd_cnt;
        pulse_save();
        wait_save(c0);
        n_checks++; if (wlog.size() !== 5 || wlog[0] !== 32'd61 || wlog[3] !== 32'd64 || whdr_log[4] !== 16'd0) begin n_fail++; $display("FAIL wrap15: n=%0d first=%0d hdr=%0d want 5/61/0", wlog.size(), wlog[0], whdr_log[4]); end
        step(3);
        clear_logs();
        hdr_word = 16'hFFFF; c0 = sd_cnt;
        pulse_save();
        wait_save(c0);
        n_checks++; if (wlog.size() !== 5 || wlog[0] !== 32'd1 || wlog[3] !== 32'd4 || whdr_log[4] !== 16'd1) begin n_fail++; $display("FAIL hdr_ffff: n=%0d first=%0d hdr=%0d want 5/1/1", wlog.size(), wlog[0], whdr_log[4]); end
        step(3);
    endtask

    task automatic test_fifo_threshold();
        int c0;
        clear_logs();
        hdr_word = 3; wfifo_cnt = 255; c0 = sd_cnt;
        pulse_save();
        step(30);
        n_checks++; if (state_o !== 3'd2 || wlog.size() !== 0 || cur_slot !== 4'd3) begin n_fail++; $display("FAIL thresh_255: state=%0d writes=%0d slot=%0d want 2/0/3", state_o, wlog.size(), cur_slot); end
        load_slot = 4; load_req = 1;
        step(1);
        load_req = 0;
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL ignore_load_busy: state=%0d want 2", state_o); end
        wfifo_cnt = 256;
        step(2);
        wfifo_cnt = 255;
        step(30);
        n_checks++; if (wlog.size() !== 1 || wlog[0] !== 32'd13) begin n_fail++; $display("FAIL thresh_256: writes=%0d addr=%0d want 1/13", wlog.size(), wlog[0]); end
        wfifo_cnt = 256;
        wait_save(c0);
        n_checks++; if (wlog.size() !== 5 || whdr_log[4] !== 16'd4 || rlog.size() !== 1) begin n_fail++; $display("FAIL thresh_finish: writes=%0d hdr=%0d reads=%0d want 5/4/1", wlog.size(), whdr_log[4], rlog.size()); end
        step(3);
    endtask

    task automatic test_load();
        int c0;
        clear_logs();
        c0 = ld_cnt; rfifo_free = 256;
        load_slot = 2; load_req = 1;
        step(1);
        load_req = 0;
        n_checks++; if (state_o !== 3'd4 || cur_slot !== 4'd2 || rd_sel !== 1'b1) begin n_fail++; $display("FAIL load_enter: state=%0d slot=%0d sel=%b want 4/2/1", state_o, cur_slot, rd_sel); end
        for (int i = 0; i < 300 && ld_cnt == c0; i++) step(1);
        n_checks++; if (ld_cnt !== c0 + 1) begin n_fail++; $display("FAIL load_timeout: done=%0d want 1", ld_cnt - c0); end
        n_checks++; if (rlog.size() !== 4 || wlog.size() !== 0) begin n_fail++; $display("FAIL load_count: reads=%0d writes=%0d want 4/0", rlog.size(), wlog.size()); end
        else
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (rlog[i] !== 32'(9 + i) || rsel_log[i] !== 1'b1) begin n_fail++; $display("FAIL load_rd%0d: addr=%0d sel=%b want %0d/1", i, rlog[i], rsel_log[i], 9 + i); end
            end
        step(3);
        n_checks++; if (state_o !== 3'd0 || ld_cnt !== c0 + 1 || rd_sel !== 1'b0) begin n_fail++; $display("FAIL load_after: state=%0d done=%0d sel=%b want 0/1/0", state_o, ld_cnt - c0, rd_sel); end
    endtask

    task automatic test_err();
        load_slot2 = 12; load_req2 = 1;
        step(1);
        load_req2 = 0;
        n_checks++; if (err2 !== 1'b1 || busy2 !== 1'b0 || state_o2 !== 3'd0) begin n_fail++; $display("FAIL err_slot12: err=%b busy=%b state=%0d want 1/0/0", err2, busy2, state_o2); end
        step(1);
        n_checks++; if (err2 !== 1'b0 || busy2 !== 1'b0) begin n_fail++; $display("FAIL err_pulse: err=%b busy=%b want 0/0", err2, busy2); end
        load_slot2 = 15; load_req2 = 1;
        step(1);
        load_req2 = 0;
        n_checks++; if (err2 !== 1'b1 || busy2 !== 1'b0) begin n_fail++; $display("FAIL err_slot15: err=%b busy=%b want 1/0", err2, busy2); end
        n_checks++; if (err_cnt !== 0) begin n_fail++; $display("FAIL err_main: count=%0d want 0", err_cnt); end
        step(2);
    endtask

    task automatic test_simultaneous();
        int c0;
        clear_logs();
        hdr_word = 0; c0 = sd_cnt; load_slot = 1;
        save_req = 1; load_req = 1;
        step(1);
        save_req = 0; load_req = 0;
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL both_req: state=%0d want 1", state_o); end
        wait_save(c0);
        n_checks++; if (sd_cnt !== c0 + 1 || wlog.size() !== 5 || wlog[0] !== 32'd1) begin n_fail++; $display("FAIL both_finish: done=%0d writes=%0d want 1/5", sd_cnt - c0, wlog.size()); end
        step(3);
    endtask

    task automatic test_init_drop();
        int c0;
        clear_logs();
        hdr_word = 7; c0 = sd_cnt;
        pulse_save();
        for (int i = 0; i < 100 && wlog.size() == 0; i++) step(1);
        n_checks++; if (wlog.size() !== 1 || state_o !== 3'd2) begin n_fail++; $display("FAIL drop_setup: writes=%0d state=%0d want 1/2", wlog.size(), state_o); end
        sd_init_done = 0;
        step(1);
        n_checks++; if (state_o !== 3'd0 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle: state=%0d busy=%b want 0/0", state_o, busy); end
        sd_init_done = 1;
        step(30);
        n_checks++; if (sd_cnt !== c0 || state_o !== 3'd0 || wlog.size() !== 1) begin n_fail++; $display("FAIL drop_nodone: done=%0d state=%0d writes=%0d want 0/0/1", sd_cnt - c0, state_o, wlog.size()); end
    endtask

    initial begin
        test_reset();
        test_save_basic();
        test_save_wrap();
        test_fifo_threshold();
        test_load();
        test_err();
        test_simultaneous();
        test_init_drop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
